// File: rtl/psum_pkg.sv
// Shared types, default widths and the drain requantizer for the psum collector.
package psum_pkg;

    localparam int DEF_PSUM_BW   = 32;
    localparam int DEF_ADDR_PSUM = 12;
    localparam int DEF_OUT_BW    = 8;
    localparam int DEF_DEPTH     = 2048;
    localparam int SHIFT_W       = 5;

    localparam logic signed [DEF_PSUM_BW-1:0] SAT_MAX = DEF_PSUM_BW'((2 ** (DEF_OUT_BW - 1)) - 1);
    localparam logic signed [DEF_PSUM_BW-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Arithmetic (floor) right shift, then clamp into the signed output range.
    function automatic logic [DEF_OUT_BW-1:0] requant(
        input logic signed [DEF_PSUM_BW-1:0] psum,
        input logic        [SHIFT_W-1:0]     sh
    );
        logic signed [DEF_PSUM_BW-1:0] shifted;
        logic signed [DEF_PSUM_BW-1:0] clamped;
        shifted = psum >>> sh;
        if (shifted > SAT_MAX)      clamped = SAT_MAX;
        else if (shifted < SAT_MIN) clamped = SAT_MIN;
        else                        clamped = shifted;
        return clamped[DEF_OUT_BW-1:0];
    endfunction

endpackage

// File: rtl/psum_buf_ram.sv
// Simple dual-port psum buffer: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old contents.
module psum_buf_ram #(
    parameter int AW    = 11,
    parameter int DW    = 32,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port and registered read port.
    // NOTE: storage arrays carry no reset; clearing 2K words would force flops instead of a RAM macro.
    // NOTE: non-blocking assignments here are what give read-old-on-collision semantics.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/psum_collector.sv
// Collects the PE-column psum stream into a private buffer (read-modify-write
// with forwarding), then drains requantized int8 values over valid/ready.
module psum_collector
    import psum_pkg::*;
#(
    parameter int ADDR_PSUM = DEF_ADDR_PSUM,
    parameter int PSUM_BW   = DEF_PSUM_BW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int OUT_BW    = DEF_OUT_BW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 overwrite,
    input  logic                 acc_end,
    input  logic                 psum_valid_in,
    input  logic [ADDR_PSUM-1:0] psum_addr_in,
    input  logic [PSUM_BW-1:0]   psum_data_in,
    input  logic                 drain_start,
    input  logic [ADDR_PSUM-1:0] drain_len,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 drain_ready,
    output logic                 drain_valid,
    output logic [OUT_BW-1:0]    drain_data,
    output logic [ADDR_PSUM-1:0] drain_addr,
    output logic                 done,
    output logic                 drop_err
);

    localparam int                   RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_PSUM:0]   DEPTH_LIM = (ADDR_PSUM + 1)'(DEPTH);
    localparam logic [ADDR_PSUM-1:0] ONE       = ADDR_PSUM'(1);

    state_t                 r_state, w_state_nxt;
    logic                   r_flush_cnt, r_overwrite, r_drop_err;
    logic [SHIFT_W-1:0]     r_shift;
    logic [ADDR_PSUM-1:0]   r_len, r_issue_ptr, r_beat_cnt, w_rd_ptr;
    logic                   w_start_go, w_drain_go, w_accept, w_drop;
    logic                   w_issue, w_fire, w_drain_last;
    logic [1:0]             w_occ;

    // Accumulate pipeline: S1 = read data returns, S2 = write, WC = committed last cycle.
    logic                   r_s1_valid, r_s2_valid, r_wc_valid;
    logic [ADDR_PSUM-1:0]   r_s1_addr, r_s2_addr, r_wc_addr;
    logic [PSUM_BW-1:0]     r_s1_data, r_s2_sum, r_wc_sum;
    logic [PSUM_BW-1:0]     w_s1_old, w_s1_sum, w_ram_rdata;
    logic                   w_ram_re;
    logic [RAM_AW-1:0]      w_ram_raddr;

    // Drain path: F = read in flight, HOLD = skid entry, OUT = presented beat.
    logic                   r_f_valid, r_hold_valid, r_out_valid;
    logic [ADDR_PSUM-1:0]   r_f_addr, r_hold_addr, r_out_addr;
    logic [OUT_BW-1:0]      r_hold_data, r_out_data, w_f_data;

    assign w_start_go   = (r_state == ST_IDLE) && start;
    assign w_drain_go   = (r_state == ST_IDLE) && !start && drain_start;
    assign w_accept     = psum_valid_in && (r_state == ST_ACCUM) && ({1'b0, psum_addr_in} < DEPTH_LIM);
    assign w_drop       = psum_valid_in && !w_accept;
    assign w_fire       = r_out_valid && drain_ready;
    assign w_drain_last = w_fire && (r_beat_cnt == r_len - ONE);
    assign w_rd_ptr     = (r_state == ST_IDLE) ? '0 : r_issue_ptr;
    assign w_occ        = {1'b0, r_out_valid} + {1'b0, r_hold_valid} + {1'b0, r_f_valid} - {1'b0, w_fire};
    assign w_issue      = (w_drain_go && (drain_len != '0)) ||
                          ((r_state == ST_DRAIN) && (r_issue_ptr < r_len) && (w_occ < 2'd2));
    assign w_f_data     = requant(w_ram_rdata, r_shift);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and done decode.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                done = 1'b1;
                if (start)            w_state_nxt = ST_ACCUM;
                else if (drain_start) w_state_nxt = ST_DRAIN;
            end
            ST_ACCUM: if (acc_end) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt) w_state_nxt = ST_IDLE;
            ST_DRAIN: if ((r_len == '0) || w_drain_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Pass control: flush timer, latched mode bits, drain pointers, sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= 1'b0;
            r_overwrite <= 1'b0;
            r_drop_err  <= 1'b0;
            r_shift     <= '0;
            r_len       <= '0;
            r_issue_ptr <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_flush_cnt <= (r_state == ST_FLUSH) ? ~r_flush_cnt : 1'b0;
            if (w_start_go) begin
                r_overwrite <= overwrite;
                r_drop_err  <= 1'b0;
            end
            if (w_drop) r_drop_err <= 1'b1;
            if (w_drain_go) begin
                r_len       <= drain_len;
                r_shift     <= shift;
                r_issue_ptr <= w_issue ? ONE : '0;
                r_beat_cnt  <= '0;
            end else begin
                if (w_issue) r_issue_ptr <= r_issue_ptr + ONE;
                if (w_fire)  r_beat_cnt  <= r_beat_cnt + ONE;
            end
        end
    end

    // Read-port arbitration and forwarding: newest in-flight write to the same address wins.
    always_comb begin
        w_ram_re    = w_accept || w_issue;
        w_ram_raddr = w_accept ? psum_addr_in[RAM_AW-1:0] : w_rd_ptr[RAM_AW-1:0];
        w_s1_old    = w_ram_rdata;
        if (r_wc_valid && (r_wc_addr == r_s1_addr)) w_s1_old = r_wc_sum;
        if (r_s2_valid && (r_s2_addr == r_s1_addr)) w_s1_old = r_s2_sum;
        w_s1_sum    = r_overwrite ? r_s1_data : (w_s1_old + r_s1_data);
    end

    // Accumulate pipeline stages S1, S2 and the committed-write record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_wc_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_wc_valid <= r_s2_valid;
            if (w_accept) begin
                r_s1_addr <= psum_addr_in;
                r_s1_data <= psum_data_in;
            end
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_s2_sum  <= w_s1_sum;
            end
            if (r_s2_valid) begin
                r_wc_addr <= r_s2_addr;
                r_wc_sum  <= r_s2_sum;
            end
        end
    end

    // Drain output stage with one-entry hold register absorbing the read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_valid    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_addr   <= '0;
        end else begin
            r_f_valid <= w_issue;
            if (w_issue) r_f_addr <= w_rd_ptr;
            if (!r_out_valid || w_fire) begin
                r_out_valid <= r_hold_valid || r_f_valid;
                if (r_hold_valid) begin
                    r_out_data   <= r_hold_data;
                    r_out_addr   <= r_hold_addr;
                    r_hold_valid <= r_f_valid;
                    if (r_f_valid) begin
                        r_hold_data <= w_f_data;
                        r_hold_addr <= r_f_addr;
                    end
                end else if (r_f_valid) begin
                    r_out_data <= w_f_data;
                    r_out_addr <= r_f_addr;
                end
            end else if (r_f_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_f_data;
                r_hold_addr  <= r_f_addr;
            end
        end
    end

    psum_buf_ram #(
        .AW    (RAM_AW),
        .DW    (PSUM_BW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .i_we    (r_s2_valid),
        .i_waddr (r_s2_addr[RAM_AW-1:0]),
        .i_wdata (r_s2_sum),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign drain_valid = r_out_valid;
    assign drain_data  = r_out_data;
    assign drain_addr  = r_out_addr;
    assign drop_err    = r_drop_err;

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed sequences, a saturation
// vector table, and randomized passes checked against an array-based model.
module tb_psum_collector;

    logic        clk = 1'b0;
    logic        rst, start, overwrite, acc_end, psum_valid_in;
    logic [11:0] psum_addr_in;
    logic [31:0] psum_data_in;
    logic        drain_start;
    logic [11:0] drain_len;
    logic [4:0]  shift;
    logic        drain_ready;
    logic        drain_valid;
    logic [7:0]  drain_data;
    logic [11:0] drain_addr;
    logic        done, drop_err;

    psum_collector dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .overwrite     (overwrite),
        .acc_end       (acc_end),
        .psum_valid_in (psum_valid_in),
        .psum_addr_in  (psum_addr_in),
        .psum_data_in  (psum_data_in),
        .drain_start   (drain_start),
        .drain_len     (drain_len),
        .shift         (shift),
        .drain_ready   (drain_ready),
        .drain_valid   (drain_valid),
        .drain_data    (drain_data),
        .drain_addr    (drain_addr),
        .done          (done),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int a; int d; } beat_t;
    typedef struct { int data; int sh; int exp; } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model [64];
    beat_t       beats [$];
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Requantization from first principles: floor division by 2^sh, then clamp.
    function automatic logic [7:0] ref_requant(input int p, input int sh);
        longint q, d;
        d = longint'(1) << sh;
        q = longint'(p) / d;
        if ((longint'(p) % d) != 0 && p < 0) q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one accumulate pass with the queued beats; checks FLUSH lasts exactly 2 cycles.
    task automatic run_accum(input bit ow, input bit end_with_last);
        start = 1'b1; overwrite = ow;
        tick();
        start = 1'b0; overwrite = 1'b0;
        foreach (beats[i]) begin
            psum_valid_in = beats[i].v;
            psum_addr_in  = 12'(beats[i].a);
            psum_data_in  = beats[i].d;
            acc_end       = end_with_last && (i == beats.size() - 1);
            if (beats[i].v && beats[i].a < 64)
                model[beats[i].a] = ow ? beats[i].d : model[beats[i].a] + beats[i].d;
            tick();
        end
        psum_valid_in = 1'b0;
        if (!end_with_last || beats.size() == 0) begin
            acc_end = 1'b1;
            tick();
        end
        acc_end = 1'b0;
        check("flush_cycle1_busy", 64'(done), 64'(1'b0));
        tick();
        check("flush_cycle2_busy", 64'(done), 64'(1'b0));
        tick();
        check("flush_to_idle", 64'(done), 64'(1'b1));
        beats.delete();
    endtask

    // Drains len entries and compares against exp_q; optional random backpressure.
    task automatic run_drain(input int len, input int sh, input bit rnd);
        int         k = 0;
        int         cyc;
        int         first = -1;
        bit         stall = 0;
        logic [7:0] pd;
        logic [11:0] pa;
        drain_start = 1'b1; drain_len = 12'(len); shift = 5'(sh);
        tick();
        drain_start = 1'b0; drain_len = '0; shift = '0;
        cyc = 1;
        if (len == 0) begin
            check("len0_in_drain", 64'(done), 64'(1'b0));
            tick();
        end
        while (k < len && cyc < 400) begin
            drain_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drain_valid) begin
                if (first < 0) first = cyc;
                if (stall) begin
                    check("stall_data_stable", 64'(drain_data), 64'(pd));
                    check("stall_addr_stable", 64'(drain_addr), 64'(pa));
                end
                if (drain_ready) begin
                    check("drain_data", 64'($signed(drain_data)), 64'($signed(exp_q[k])));
                    check("drain_addr", 64'(drain_addr), 64'(k));
                    k++;
                end
                stall = !drain_ready;
                pd    = drain_data;
                pa    = drain_addr;
            end else begin
                stall = 0;
            end
            tick();
            cyc++;
        end
        drain_ready = 1'b0;
        check("drain_beat_count", 64'(k), 64'(len));
        if (len > 0) check("first_valid_within_2", 64'(first >= 1 && first <= 2), 64'(1));
        check("drain_end_done", 64'(done), 64'(1'b1));
        check("drain_end_valid_low", 64'(drain_valid), 64'(1'b0));
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        int   k;
        int   cyc;
        int   prev_a;

        rst = 1'b1; start = 0; overwrite = 0; acc_end = 0; psum_valid_in = 0;
        psum_addr_in = '0; psum_data_in = '0; drain_start = 0; drain_len = '0;
        shift = '0; drain_ready = 0;
        foreach (model[i]) model[i] = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_done",        64'(done),        64'(1'b1));
        check("rst_drain_valid", 64'(drain_valid), 64'(1'b0));
        check("rst_drain_data",  64'(drain_data),  64'(0));
        check("rst_drain_addr",  64'(drain_addr),  64'(0));
        check("rst_drop_err",    64'(drop_err),    64'(1'b0));

        // Plain overwrite pass, then drain 4 at shift 0.
        beats.push_back('{1'b1, 0, 10});
        beats.push_back('{1'b1, 1, 20});
        beats.push_back('{1'b1, 2, -5});
        beats.push_back('{1'b1, 3, 7});
        run_accum(1'b1, 1'b0);
        exp_q = '{8'd10, 8'd20, 8'hFB, 8'd7};
        run_drain(4, 0, 1'b0);

        // Back-to-back accumulation into one address exercises forwarding.
        beats.push_back('{1'b1, 4, 0});
        beats.push_back('{1'b1, 5, 100});
        run_accum(1'b1, 1'b0);
        beats.push_back('{1'b1, 5, 1});
        beats.push_back('{1'b1, 5, 2});
        beats.push_back('{1'b1, 5, 3});
        run_accum(1'b0, 1'b1);
        exp_q = '{8'd10, 8'd20, 8'hFB, 8'd7, 8'd0, 8'd106};
        run_drain(6, 0, 1'b0);

        // Backpressure: random ready.
        exp_q = '{8'd10, 8'd20, 8'hFB, 8'd7};
        run_drain(4, 0, 1'b1);

        // Zero-length drain.
        run_drain(0, 0, 1'b0);

        // Reset mid-drain after two beats, then re-drain.
        drain_start = 1'b1; drain_len = 12'd4; shift = '0;
        tick();
        drain_start = 1'b0; drain_ready = 1'b1;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 20) begin
            if (drain_valid) begin
                check("pre_rst_addr", 64'(drain_addr), 64'(k));
                k++;
            end
            tick();
            cyc++;
        end
        check("pre_rst_beats", 64'(k), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0; drain_ready = 1'b0;
        check("rst_mid_drain_valid", 64'(drain_valid), 64'(1'b0));
        check("rst_mid_drain_done",  64'(done),        64'(1'b1));
        exp_q = '{8'd10, 8'd20, 8'hFB, 8'd7};
        run_drain(4, 0, 1'b0);

        // Drops: out-of-range address, then a beat during FLUSH.
        beats.push_back('{1'b1, 2048, 9});
        run_accum(1'b0, 1'b0);
        check("drop_out_of_range", 64'(drop_err), 64'(1'b1));
        run_accum(1'b0, 1'b0);
        check("drop_cleared_by_start", 64'(drop_err), 64'(1'b0));
        start = 1'b1; overwrite = 1'b1;
        tick();
        start = 1'b0; overwrite = 1'b0; acc_end = 1'b1;
        tick();
        acc_end = 1'b0; psum_valid_in = 1'b1; psum_addr_in = '0; psum_data_in = 55;
        tick();
        psum_valid_in = 1'b0;
        check("drop_in_flush", 64'(drop_err), 64'(1'b1));
        tick();
        check("flush_drop_idle", 64'(done), 64'(1'b1));
        exp_q = '{8'd10};
        run_drain(1, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("drop_clear_on_start", 64'(drop_err), 64'(1'b0));
        acc_end = 1'b1;
        tick();
        acc_end = 1'b0;
        tick(); tick();

        // Requantization / saturation table: single entry at addr 0.
        tbl[0]  = '{1000, 2, 127};
        tbl[1]  = '{-1000, 2, -128};
        tbl[2]  = '{-3, 1, -2};
        tbl[3]  = '{508, 2, 127};
        tbl[4]  = '{-1, 3, -1};
        tbl[5]  = '{255, 1, 127};
        tbl[6]  = '{-256, 1, -128};
        tbl[7]  = '{int'(32'h7FFF_FFFF), 31, 0};
        tbl[8]  = '{int'(32'h8000_0000), 31, -1};
        tbl[9]  = '{300, 1, 127};
        tbl[10] = '{-9, 2, -3};
        tbl[11] = '{64, 0, 64};
        foreach (tbl[i]) begin
            beats.push_back('{1'b1, 0, tbl[i].data});
            run_accum(1'b1, 1'b0);
            exp_q.push_back(8'(tbl[i].exp));
            run_drain(1, tbl[i].sh, 1'b0);
        end

        // Randomized passes against the model over a 16-entry window.
        for (int a = 0; a < 16; a++) beats.push_back('{1'b1, a, int'($urandom)});
        run_accum(1'b1, 1'b1);
        for (int pass = 0; pass < 12; pass++) begin
            int n, len, sh;
            bit ow;
            ow     = ($urandom_range(0, 5) == 0);
            n      = $urandom_range(5, 25);
            prev_a = 0;
            for (int b = 0; b < n; b++) begin
                beat_t bt;
                bt.v   = ($urandom_range(0, 3) != 0);
                bt.a   = ($urandom_range(0, 2) == 0) ? prev_a : $urandom_range(0, 15);
                bt.d   = ($urandom_range(0, 4) == 0) ? int'($urandom)
                                                      : int'($urandom_range(0, 400)) - 200;
                prev_a = bt.a;
                beats.push_back(bt);
            end
            run_accum(ow, 1'($urandom_range(0, 1)));
            len = $urandom_range(0, 16);
            sh  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
            for (int a = 0; a < len; a++) exp_q.push_back(ref_requant(model[a], sh));
            run_drain(len, sh, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Receiving end of the PE-column psum stream: consumes (valid, addr, data) beats from the top PE of a column.
- Does a read-modify-write accumulate into a private psum buffer, with hazard forwarding.
- After the core signals end of pass, drains the buffer toward the AXI side as requantized signed 8-bit values using a valid/ready handshake.

Parameters:
- ADDR_PSUM, 12, psum address width.
- PSUM_BW, 32, signed psum width.
- DEPTH, 2048, buffer entries (32 x 64 tile); addresses >= DEPTH are ignored.
- OUT_BW, 8, drained output width after requantization.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (fixed)
- start  in  1  begin accumulate pass; sampled in IDLE only
- overwrite  in  1  latched at start; 1 = store incoming psum, 0 = add to stored value
- acc_end  in  1  pulse: no further psums in this pass
- psum_valid_in  in  1  psum beat valid (no backpressure)
- psum_addr_in  in  ADDR_PSUM  psum address
- psum_data_in  in  PSUM_BW  signed psum
- drain_start  in  1  begin drain; sampled in IDLE only
- drain_len  in  ADDR_PSUM  entries to drain, addresses 0..drain_len-1; latched
- shift  in  5  arithmetic right shift for requant; latched at drain_start
- drain_ready  in  1  sink ready
- drain_valid  out  1  output beat valid
- drain_data  out  OUT_BW  requantized value
- drain_addr  out  ADDR_PSUM  address of drained entry
- done  out  1  high when state == IDLE
- drop_err  out  1  sticky: a beat was dropped

Behaviour:
- States: IDLE, ACCUM, FLUSH, DRAIN.
  - IDLE -> ACCUM on start.
  - Else IDLE -> DRAIN on drain_start; start wins if both are asserted.
  - ACCUM -> FLUSH on acc_end.
  - FLUSH -> IDLE after exactly 2 cycles.
  - DRAIN -> IDLE after the last beat handshake.
  - start or drain_start outside IDLE: ignored.
- Reset: state IDLE, drain_valid 0, drain_data 0, drain_addr 0, drop_err 0, pipeline valids 0. done is 1 after reset. Buffer contents are not cleared. Reset mid-operation aborts to IDLE the next cycle.
- Accumulate pipeline (ACCUM, and the beat in the acc_end cycle):
  - S0 (accept cycle t): issue synchronous read of addr.
  - S1 (t+1): sum = overwrite ? data : rd + data.
  - S2 (t+2): write sum.
  - Buffer holds the new value from cycle t+3 onward. Accepts 1 beat per cycle.
- Addition is modulo 2^PSUM_BW, with no saturation.
- Hazard forwarding: if S1's address matches a beat in S2, or a write committed in the previous cycle, the newest matching value replaces the read data. Back-to-back beats to the same address must give the exact sum.
- Dropped beats:
  - psum_valid_in in FLUSH, DRAIN or IDLE: beat dropped, drop_err set.
  - Address >= DEPTH: beat dropped, drop_err set.
  - drop_err is cleared only by rst or an accepted start.
- Drain:
  - Entries are read in address order 0..drain_len-1.
  - Requant: v = psum >>> shift (arithmetic, floor), saturated to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1].
  - A beat transfers when drain_valid & drain_ready.
  - While drain_valid=1 and drain_ready=0, drain_data and drain_addr stay stable. Uses a 1-entry hold register, absorbing the 1-cycle read latency; no bubbles when ready stays high after the first beat.
  - First drain_valid appears at most 2 cycles after drain_start.
  - drain_len = 0: DRAIN for one cycle, no beats, back to IDLE.
  - drain_addr increments per handshake; no wrap past drain_len-1.

Decomposition:
- Shared package psum_pkg: state encoding (IDLE=0, ACCUM=1, FLUSH=2, DRAIN=3), PSUM_BW, ADDR_PSUM, OUT_BW defaults, and a requant saturation function.
- One sub-module: psum_buf_ram, simple dual-port RAM (1 write, 1 read port, sync read, read-old-on-collision). Forwarding logic stays in psum_collector.

Test Plan:
1. Overwrite pass, beats addr 0..3 = 10, 20, -5, 7; acc_end; drain len 4, shift 0 -> beats (0,10), (1,20), (2,-5), (3,7); done=1 after.
2. Overwrite addr5 = 100; accumulate pass with addr5 +1, +2, +3 on consecutive cycles -> drain of addr5 = 106 (checks forwarding).
3. Saturation, shift 2: addr0=1000 -> 127; addr1=-1000 -> -128; addr2=-3 with shift 1 -> -2; addr3=508 with shift 2 -> 127.
4. Drain 4 entries with drain_ready toggling pseudo-randomly -> exactly 4 handshakes, data stable while stalled, in-order addresses.
5. psum_valid_in asserted in the FLUSH cycle (addr 0 = 55) -> drop_err=1 and addr 0 unchanged; drop_err clears on next start.
6. rst asserted mid-DRAIN (after 2 beats) -> drain_valid=0 and done=1 the next cycle; re-drain returns the original values.
